// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Oversampled UART transmitter. Sends one start bit, DATA_BITS
//            data bits (LSB first) and one stop bit. A rising edge on
//            tx_start requests a frame. One extra request made during a
//            frame is queued and sent straight after it.
// Ports    : clk      - single clock, rising edge
//            rst      - asynchronous, active-high reset
//            tx_start - transmit request; only rising edges count
//            data_in  - frame payload, sampled when the frame is accepted
//            dvsr     - baud divisor (one tick every dvsr+1 clocks),
//                       sampled when the frame is accepted
//            tx       - registered serial output, idles high
//            tx_done  - registered one-cycle pulse in the last frame cycle
//            busy     - high while a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [10:0]          dvsr,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 busy
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           state_q,   state_d;
  logic                 start_q;
  logic                 pending_q, pending_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [10:0]          dvsr_q,    dvsr_d;
  logic [10:0]          baud_q,    baud_d;
  logic [TW-1:0]        tick_q,    tick_d;
  logic [BW-1:0]        bit_q,     bit_d;
  logic                 tx_q,      tx_d;
  logic                 done_q,    done_d;

  logic                 w_rise;
  logic                 w_accept;
  logic                 w_tick;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic [DATA_BITS-1:0] w_shift_nxt;

  assign w_rise      = tx_start & ~start_q;
  assign w_accept    = (state_q == S_IDLE) & (w_rise | pending_q);
  assign w_tick      = (state_q != S_IDLE) & (baud_q == dvsr_q);
  assign w_bit_end   = w_tick & (tick_q == OS_LAST);
  assign w_stop_end  = w_tick & (tick_q == ST_LAST);
  assign w_shift_nxt = shift_q >> 1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_START;
      S_START: if (w_bit_end) state_d = S_DATA;
      S_DATA:  if (w_bit_end && (bit_q == BIT_LAST)) state_d = S_STOP;
      S_STOP:  if (w_stop_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    pending_d = pending_q;
    shift_d   = shift_q;
    dvsr_d    = dvsr_q;
    baud_d    = baud_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    tx_d      = tx_q;

    if (state_q != S_IDLE) begin
      baud_d = w_tick ? 11'd0 : (baud_q + 11'd1);
      // At most one request is remembered while a frame is running.
      if (w_rise) pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (w_accept) begin
          shift_d   = data_in;
          dvsr_d    = dvsr;
          baud_d    = 11'd0;
          tick_d    = '0;
          pending_d = 1'b0;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (w_bit_end) begin
            tick_d = '0;
            bit_d  = '0;
            tx_d   = shift_q[0];
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (w_bit_end) begin
            tick_d = '0;
            if (bit_q == BIT_LAST) begin
              tx_d = 1'b1;
            end else begin
              shift_d = w_shift_nxt;
              tx_d    = w_shift_nxt[0];
              bit_d   = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_stop_end) begin
            tick_d = '0;
            tx_d   = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: tx_d = 1'b1;
    endcase

    // Look one cycle ahead so the registered pulse lands in the final
    // busy cycle, i.e. the cycle holding the last stop tick.
    done_d = (state_d == S_STOP) && (tick_d == ST_LAST) && (baud_d == dvsr_d);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b0;
      pending_q <= 1'b0;
      shift_q   <= '0;
      dvsr_q    <= 11'd0;
      baud_q    <= 11'd0;
      tick_q    <= '0;
      bit_q     <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      start_q   <= tx_start;
      pending_q <= pending_d;
      shift_q   <= shift_d;
      dvsr_q    <= dvsr_d;
      baud_q    <= baud_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. A waveform model predicts the
//            serial line cycle by cycle; directed scenarios add literal
//            expectations on frame length, bit values and tx_done timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int ST = 16;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        tx_start = 1'b0;
  logic [7:0]  data_in  = 8'h00;
  logic [10:0] dvsr     = 11'd0;
  logic        tx;
  logic        tx_done;
  logic        busy;

  uart_tx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_TICKS(ST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .data_in (data_in),
    .dvsr    (dvsr),
    .tx      (tx),
    .tx_done (tx_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: queue of line levels still to be driven by the current frame.
  logic m_q[$];
  logic m_prev = 1'b0;
  logic m_pend = 1'b0;

  int   cyc_n     = 0;
  int   busy_cnt  = 0;
  int   done_cnt  = 0;
  int   done_idle = 0;
  int   start_cyc = 0;
  int   done_cyc  = 0;
  int   done_at   = 0;
  logic prev_busy = 1'b0;
  logic rec [4096];

  int         b0, d0, di0;
  logic [9:0] pat;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc_n, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_step();
    logic rise;
    logic lvl;
    int   n;
    rise   = tx_start && !m_prev;
    m_prev = tx_start;
    if (m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (rise) m_pend = 1'b1;
    end else if (rise || m_pend) begin
      m_pend = 1'b0;
      for (int i = 0; i < DB + 2; i++) begin
        if (i == 0)       lvl = 1'b0;
        else if (i <= DB) lvl = data_in[i-1];
        else              lvl = 1'b1;
        n = ((i <= DB) ? OS : ST) * (int'(dvsr) + 1);
        repeat (n) m_q.push_back(lvl);
      end
    end
  endtask

  task automatic compare();
    logic e_tx, e_busy, e_done;
    if (rst) begin
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_busy = (m_q.size() > 0);
      e_tx   = e_busy ? m_q[0] : 1'b1;
      e_done = (m_q.size() == 1);
    end
    check1("tx", tx, e_tx);
    check1("busy", busy, e_busy);
    check1("tx_done", tx_done, e_done);
  endtask

  // One clock: advance the model on the edge, check 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare();
    cyc_n++;
    if (busy === 1'b1) begin
      if (!prev_busy) start_cyc = cyc_n;
      if (busy_cnt < 4096) rec[busy_cnt] = tx;
      busy_cnt++;
    end
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
      done_at  = busy_cnt - 1;
      if (busy !== 1'b1) done_idle++;
    end
    prev_busy = (busy === 1'b1);
  endtask

  task automatic snap();
    b0  = busy_cnt;
    d0  = done_cnt;
    di0 = done_idle;
  endtask

  task automatic check_bits(input string name, input int base, input int step);
    for (int k = 0; k < 10; k++) begin
      check1(name, rec[base + step * k], pat[k]);
    end
  endtask

  initial begin
    model_reset();

    // Reset and quiet idle
    #1 rst = 1'b1;
    model_reset();
    #1;
    check1("rst_tx", tx, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", tx_done, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;
    snap();
    repeat (100) cyc();
    checkn("idle_busy_cycles", busy_cnt - b0, 0);
    checkn("idle_done_pulses", done_cnt - d0, 0);

    // 0x55 at dvsr=0
    snap();
    data_in = 8'h55; dvsr = 11'd0; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (175) cyc();
    checkn("f55_busy_cycles", busy_cnt - b0, 160);
    checkn("f55_done_pulses", done_cnt - d0, 1);
    checkn("f55_done_pos", done_at - b0, 159);
    checkn("f55_done_outside_busy", done_idle - di0, 0);
    check1("f55_start_last", rec[b0 + 15], 1'b0);
    check1("f55_bit0_first", rec[b0 + 16], 1'b1);
    pat = 10'b1010101010;
    check_bits("f55_bit", b0 + 8, 16);

    // 0xA3 at dvsr=2, inputs disturbed at clock 100
    snap();
    data_in = 8'hA3; dvsr = 11'd2; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (99) cyc();
    dvsr = 11'd0; data_in = 8'h00;
    repeat (400) cyc();
    checkn("fa3_busy_cycles", busy_cnt - b0, 480);
    checkn("fa3_done_pulses", done_cnt - d0, 1);
    checkn("fa3_done_pos", done_at - b0, 479);
    pat = 10'b1101000110;
    check_bits("fa3_bit", b0 + 24, 48);

    // Queued frame: second rise at clock 50, third rise absorbed
    snap();
    data_in = 8'h3C; dvsr = 11'd0; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (49) cyc();
    data_in = 8'h0F; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (29) cyc();
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (85) cyc();
    checkn("queued_idle_gap", start_cyc - done_cyc, 2);
    repeat (170) cyc();
    checkn("queued_busy_cycles", busy_cnt - b0, 320);
    checkn("queued_done_pulses", done_cnt - d0, 2);
    pat = 10'b1000011110;
    check_bits("queued_bit", b0 + 160 + 8, 16);

    // Rise on the same edge that ends the frame
    snap();
    data_in = 8'h81; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (159) cyc();
    data_in = 8'hC3; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (3) cyc();
    checkn("edge_rise_idle_gap", start_cyc - done_cyc, 2);
    repeat (170) cyc();
    checkn("edge_rise_busy_cycles", busy_cnt - b0, 320);
    checkn("edge_rise_done_pulses", done_cnt - d0, 2);
    pat = 10'b1110000110;
    check_bits("edge_rise_bit", b0 + 160 + 8, 16);

    // Reset at clock 70 of a frame
    snap();
    data_in = 8'h00; tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    repeat (69) cyc();
    check1("pre_abort_tx", tx, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check1("abort_tx", tx, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", tx_done, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;
    repeat (200) cyc();
    checkn("abort_busy_cycles", busy_cnt - b0, 70);
    checkn("abort_done_pulses", done_cnt - d0, 0);

    // tx_start high across reset release, then held for 1000 clocks
    rst = 1'b1;
    model_reset();
    data_in = 8'h5A; tx_start = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    snap();
    cyc();
    check1("release_rise_busy", busy, 1'b1);
    repeat (999) cyc();
    tx_start = 1'b0;
    repeat (5) cyc();
    checkn("held_busy_cycles", busy_cnt - b0, 160);
    checkn("held_done_pulses", done_cnt - d0, 1);
    pat = 10'b1010110100;
    check_bits("held_bit", b0 + 8, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: baud ticks per start and data bit.
REQ-003 SHALL have parameter STOP_TICKS, default 16: baud ticks in the stop bit.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port tx_start  input  1: transmit request level; only rising edges are significant.
REQ-007 SHALL have port data_in  input  DATA_BITS: byte to send; sampled at frame acceptance.
REQ-008 SHALL have port dvsr  input  11: baud divisor; one tick every dvsr+1 clocks; sampled at frame acceptance.
REQ-009 SHALL have port tx  output  1: registered serial line; idle high.
REQ-010 SHALL have port tx_done  output  1: registered one-cycle pulse at frame end.
REQ-011 SHALL have port busy  output  1: high whenever state is not IDLE.

Function
REQ-012 SHALL register tx_start every clock into start_q; rise = tx_start AND NOT start_q.
REQ-013 SHALL have states IDLE, START, DATA and STOP, encoded in a single state register.
REQ-014 In IDLE with rise or pending set, SHALL on that edge: latch data_in into shift register, latch dvsr, clear baud and tick counters, clear pending, set tx=0, go to START.
REQ-015 Outside IDLE, SHALL run the baud counter 0..dvsr_latched, asserting tick for one clock when it equals dvsr_latched, then wrap to 0; dvsr=0 gives a tick every clock.
REQ-016 In START, SHALL increment the tick counter on each tick; on tick OVERSAMPLE-1, SHALL go to DATA, set tx = shift[0], clear the tick counter and bit counter.
REQ-017 In DATA, after OVERSAMPLE ticks per bit, SHALL shift right and drive the next bit; after bit DATA_BITS-1 completes, SHALL set tx=1 and go to STOP.
REQ-018 In STOP, on tick STOP_TICKS-1, SHALL pulse tx_done for exactly one clock and return to IDLE with tx=1.
REQ-019 Frame length SHALL be exactly ((1+DATA_BITS)*OVERSAMPLE+STOP_TICKS)*(dvsr_latched+1) clocks, i.e. 160*(D+1) at defaults.
REQ-020 A rise while not IDLE SHALL set pending; any further rises while pending is set SHALL be absorbed, giving at most one queued frame.
REQ-021 A rise in the same cycle as the STOP-to-IDLE transition SHALL set pending and be accepted on the next clock.
REQ-022 Changes to data_in or dvsr mid-frame SHALL NOT affect the frame in progress.
REQ-023 tx_start held high continuously SHALL produce exactly one frame.
REQ-024 tx SHALL be glitch-free: driven only from a flop, never combinationally.

Reset
REQ-025 On rst assertion, SHALL set the following asynchronously: state=IDLE, tx=1, tx_done=0, busy=0, pending=0, start_q=0, and all counters, shift register and dvsr latch to 0.
REQ-026 Reset mid-frame SHALL abort the frame without a tx_done pulse; tx SHALL be 1 immediately.
REQ-027 If tx_start is high when rst deasserts, the first clock SHALL see a rise and start a frame.

Verification
REQ-028 Reset: assert rst with tx_start=0 -> tx=1, busy=0, tx_done=0, and they stay so for 100 clocks after release.
REQ-029 dvsr=0, data_in=0x55, pulse tx_start -> tx sequence 0,1,0,1,0,1,0,1,0,1, each level lasting 16 clocks; busy high 160 clocks; tx_done a single pulse in the last busy cycle.
REQ-030 dvsr=2, data_in=0xA3 -> bits 0,1,1,0,0,0,1,0,1,1, each 48 clocks; frame 480 clocks; change dvsr to 0 at clock 100 -> timing unchanged.
REQ-031 dvsr=0, second tx_start rise at clock 50 of a frame with data_in changed to 0x0F -> exactly one IDLE cycle after tx_done, then a frame carrying 0x0F; a third rise during the first frame adds no frame.
REQ-032 Assert rst at clock 70 of a frame -> tx=1 in the same cycle, no tx_done; after release with tx_start low -> stays idle.
REQ-033 Hold tx_start high for 1000 clocks at dvsr=0 -> exactly one frame and one tx_done pulse.
